// File: rtl/phase_scan_ctrl.sv
// PLL dynamic-phase scan controller: counts detA pulses over a dwell window at each phase step.
// Optional macro PHASE_SCAN_RETURN_EN adds a RETURN state that walks the phase back afterwards.
module phase_scan_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DONE_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  num_steps,
  input  logic [15:0] dwell,
  input  logic [2:0]  veto_cfg,
  input  logic        detA,
  input  logic        phasedone,
  output logic        phasestep,
  output logic        phaseupdown,
  output logic [2:0]  vetoLast,
  output logic [15:0] result_count,
  output logic [7:0]  result_step,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef PHASE_SCAN_RETURN_EN
  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_WAIT_DONE, S_SETTLE, S_DWELL, S_REPORT, S_RETURN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_WAIT_DONE, S_SETTLE, S_DWELL, S_REPORT
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  steps_q, steps_d;
  logic [15:0] dwell_q, dwell_d;
  logic [2:0]  veto_q, veto_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] det_q, det_d;
  logic [15:0] res_cnt_q, res_cnt_d;
  logic [7:0]  res_step_q, res_step_d;
  logic        res_valid_q, res_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        seen_low_q, seen_low_d;
  logic [16:0] cnt_inc;
  logic        end_scan;
`ifdef PHASE_SCAN_RETURN_EN
  logic [7:0]  ret_idx_q, ret_idx_d;
  logic        returning_q, returning_d;
`endif

  assign phasestep    = (state_q == S_STEP);
`ifdef PHASE_SCAN_RETURN_EN
  assign phaseupdown  = (state_q == S_STEP) && !returning_q;
`else
  assign phaseupdown  = (state_q == S_STEP);
`endif
  assign vetoLast     = busy_q ? veto_q : 3'b000;
  assign result_count = res_cnt_q;
  assign result_step  = res_step_q;
  assign result_valid = res_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

  always_comb begin
    state_d     = state_q;
    steps_d     = steps_q;
    dwell_d     = dwell_q;
    veto_d      = veto_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    det_d       = det_q;
    res_cnt_d   = res_cnt_q;
    res_step_d  = res_step_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    seen_low_d  = seen_low_q;
    end_scan    = 1'b0;
    cnt_inc     = {1'b0, cnt_q} + 17'd1;
`ifdef PHASE_SCAN_RETURN_EN
    ret_idx_d   = ret_idx_q;
    returning_d = returning_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          steps_d = num_steps;
          dwell_d = (dwell == 16'd0) ? 16'd1 : dwell;
          veto_d  = veto_cfg;
          idx_d   = 8'd0;
          cnt_d   = 16'd0;
          det_d   = 16'd0;
          busy_d  = 1'b1;
          error_d = 1'b0;
          state_d = S_DWELL;
`ifdef PHASE_SCAN_RETURN_EN
          ret_idx_d   = 8'd0;
          returning_d = 1'b0;
`endif
        end
      end
      S_DWELL: begin
        cnt_d = cnt_q + 16'd1;
        det_d = (detA && det_q != 16'hFFFF) ? det_q + 16'd1 : det_q;
        if (cnt_inc >= {1'b0, dwell_q}) begin
          res_cnt_d   = det_d;
          res_step_d  = idx_q;
          res_valid_d = 1'b1;
          state_d     = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_valid_q && result_ready) begin
          res_valid_d = 1'b0;
          if (idx_q == steps_q) begin
`ifdef PHASE_SCAN_RETURN_EN
            state_d = S_RETURN;
`else
            end_scan = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 8'd1;
            cnt_d   = 16'd0;
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_inc >= 17'd2) begin
          cnt_d      = 16'd0;
          seen_low_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 16'd1;
        if (!phasedone) seen_low_d = 1'b1;
        // Only a rising phasedone counts; a level left high from before the step is ignored.
        if (seen_low_q && phasedone) begin
          cnt_d = 16'd0;
`ifdef PHASE_SCAN_RETURN_EN
          state_d = returning_q ? S_RETURN : S_SETTLE;
`else
          state_d = S_SETTLE;
`endif
        end else if (cnt_inc >= 17'(DONE_TIMEOUT)) begin
          error_d  = 1'b1;
          end_scan = 1'b1;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_inc >= 17'(SETTLE_CYCLES)) begin
          cnt_d   = 16'd0;
          det_d   = 16'd0;
          state_d = S_DWELL;
        end
      end
`ifdef PHASE_SCAN_RETURN_EN
      S_RETURN: begin
        if (ret_idx_q == steps_q) begin
          end_scan = 1'b1;
        end else begin
          ret_idx_d   = ret_idx_q + 8'd1;
          returning_d = 1'b1;
          cnt_d       = 16'd0;
          state_d     = S_STEP;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (end_scan) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    // Abort overrides everything, including a coincident timeout (error keeps its value).
    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      res_valid_d = 1'b0;
      error_d     = error_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      steps_q     <= 8'd0;
      dwell_q     <= 16'd0;
      veto_q      <= 3'd0;
      idx_q       <= 8'd0;
      cnt_q       <= 16'd0;
      det_q       <= 16'd0;
      res_cnt_q   <= 16'd0;
      res_step_q  <= 8'd0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      seen_low_q  <= 1'b0;
`ifdef PHASE_SCAN_RETURN_EN
      ret_idx_q   <= 8'd0;
      returning_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      steps_q     <= steps_d;
      dwell_q     <= dwell_d;
      veto_q      <= veto_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      det_q       <= det_d;
      res_cnt_q   <= res_cnt_d;
      res_step_q  <= res_step_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      seen_low_q  <= seen_low_d;
`ifdef PHASE_SCAN_RETURN_EN
      ret_idx_q   <= ret_idx_d;
      returning_q <= returning_d;
`endif
    end
  end

endmodule

// File: tb/tb_phase_scan_ctrl.sv
// Self-checking bench for phase_scan_ctrl: scoreboard of expected (count, step) results,
// a PLL model answering phasestep, and a detA generator aligned to each dwell window.
`timescale 1ns/1ps
module tb_phase_scan_ctrl;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 255;
`ifdef PHASE_SCAN_RETURN_EN
  localparam int EXP_DN = 2;
`else
  localparam int EXP_DN = 0;
`endif

  logic        clk;
  logic        reset_n, start, abort, detA, phasedone, result_ready;
  logic [7:0]  num_steps;
  logic [15:0] dwell;
  logic [2:0]  veto_cfg;
  logic        phasestep, phaseupdown, result_valid, busy, done, error;
  logic [2:0]  vetoLast;
  logic [15:0] result_count;
  logic [7:0]  result_step;

  phase_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DONE_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .num_steps(num_steps), .dwell(dwell), .veto_cfg(veto_cfg),
    .detA(detA), .phasedone(phasedone), .phasestep(phasestep),
    .phaseupdown(phaseupdown), .vetoLast(vetoLast),
    .result_count(result_count), .result_step(result_step),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Window anchors: win_a set when a start is issued, win_b by the PLL model on phasedone.
  int win_a = -1000;
  int win_b = -1000;
  bit det_hold = 1'b0;
  bit pll_stuck = 1'b0;

  initial begin
    detA = 1'b0;
    forever begin
      @(negedge clk);
      detA = det_hold || ((cyc - win_a) inside {0, 2, 4}) || ((cyc - win_b) inside {0, 2, 4});
    end
  end

  initial begin
    int pd_cnt;
    phasedone = 1'b1;
    pd_cnt = 0;
    forever begin
      @(negedge clk);
      if (pll_stuck) begin
        phasedone = 1'b1;
        pd_cnt = 0;
      end else if (phasestep) begin
        phasedone = 1'b0;
        pd_cnt = 4;
      end else if (pd_cnt > 0) begin
        pd_cnt--;
        if (pd_cnt == 0) begin
          phasedone = 1'b1;
          win_b = cyc + SETTLE + 1;
        end
      end
    end
  end

  // Scoreboard and observation state
  int exp_cnt_q[$];
  int exp_step_q[$];
  int got_cnt_q[$];
  int got_step_q[$];
  int up_steps, dn_steps, bad_width, order_bad, done_seen, step_run;
  bit run_dir, timed_out;
  int e_c, e_s, g_c, g_s;

  task automatic gap_and_clear();
    repeat (30) @(negedge clk);
    got_cnt_q.delete(); got_step_q.delete();
    exp_cnt_q.delete(); exp_step_q.delete();
    up_steps = 0; dn_steps = 0; bad_width = 0; order_bad = 0;
    done_seen = 0; step_run = 0; timed_out = 1'b0;
  endtask

  task automatic observe(input int max_cyc);
    int n;
    bit fin;
    n = 0;
    fin = 1'b0;
    while (!fin && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (result_valid && result_ready) begin
        got_cnt_q.push_back(int'(result_count));
        got_step_q.push_back(int'(result_step));
      end
      if (phasestep) begin
        step_run++;
        run_dir = phaseupdown;
      end else if (step_run > 0) begin
        if (step_run != 2) bad_width++;
        if (run_dir) begin
          up_steps++;
          if (dn_steps > 0) order_bad++;
        end else dn_steps++;
        step_run = 0;
      end
      if (done) begin
        done_seen++;
        fin = 1'b1;
      end
    end
    if (!fin) timed_out = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] n, input logic [15:0] d, input logic [2:0] v,
                          input bit with_abort);
    @(negedge clk);
    num_steps = n; dwell = d; veto_cfg = v;
    start = 1'b1;
    abort = with_abort;
    win_a = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {phasestep, phaseupdown, vetoLast, result_count, result_step,
            result_valid, busy, done, error};
    n_checks++;
    if (outs !== 33'd0) $display("FAIL reset_outputs: got %h want 0", outs);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_basic();
    gap_and_clear();
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_cnt_q.push_back(3);
      exp_step_q.push_back(i);
    end
    do_start(8'd2, 16'd10, 3'd2, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || vetoLast !== 3'd2) $display("FAIL basic_busy: busy=%b veto=%0d want 1 2", busy, vetoLast);
    else n_pass++;
    observe(3000);
    n_checks++;
    if (timed_out) $display("FAIL basic_done_wait: got no done want done within 3000 cycles");
    else n_pass++;
    while (exp_cnt_q.size() > 0) begin
      e_c = exp_cnt_q.pop_front(); e_s = exp_step_q.pop_front();
      n_checks++;
      if (got_cnt_q.size() == 0) $display("FAIL basic_result: got none want (%0d,%0d)", e_c, e_s);
      else begin
        g_c = got_cnt_q.pop_front(); g_s = got_step_q.pop_front();
        if (g_c !== e_c || g_s !== e_s) $display("FAIL basic_result: got (%0d,%0d) want (%0d,%0d)", g_c, g_s, e_c, e_s);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_cnt_q.size() != 0) $display("FAIL basic_extra: got %0d extra results want 0", got_cnt_q.size());
    else n_pass++;
    n_checks++;
    if (up_steps != 2 || dn_steps != EXP_DN || bad_width != 0 || order_bad != 0)
      $display("FAIL basic_steps: got up=%0d dn=%0d badw=%0d ord=%0d want up=2 dn=%0d badw=0 ord=0",
               up_steps, dn_steps, bad_width, order_bad, EXP_DN);
    else n_pass++;
    n_checks++;
    if (done_seen != 1 || busy !== 1'b0 || error !== 1'b0 || vetoLast !== 3'd0)
      $display("FAIL basic_end: got done=%0d busy=%b err=%b veto=%0d want 1 0 0 0", done_seen, busy, error, vetoLast);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: got done=%b want 0 one cycle later", done);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n, stable_bad;
    logic [15:0] held_c;
    logic [7:0]  held_s;
    gap_and_clear();
    result_ready = 1'b0;
    exp_cnt_q.push_back(3); exp_step_q.push_back(0);
    exp_cnt_q.push_back(3); exp_step_q.push_back(1);
    do_start(8'd1, 16'd10, 3'd0, 1'b0);
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!result_valid) $display("FAIL bp_valid: got result_valid=0 want 1 within 100 cycles");
    else n_pass++;
    held_c = result_count;
    held_s = result_step;
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) num_steps = 8'd9;
      if (!result_valid || result_count !== held_c || result_step !== held_s || phasestep) stable_bad++;
    end
    start = 1'b0;
    n_checks++;
    if (stable_bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stable_bad);
    else n_pass++;
    result_ready = 1'b1;
    got_cnt_q.push_back(int'(held_c));
    got_step_q.push_back(int'(held_s));
    @(negedge clk);
    n_checks++;
    if (phasestep !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL bp_resume: got phasestep=%b valid=%b want 1 0", phasestep, result_valid);
    else n_pass++;
    step_run = 1;
    run_dir = phaseupdown;
    observe(3000);
    while (exp_cnt_q.size() > 0) begin
      e_c = exp_cnt_q.pop_front(); e_s = exp_step_q.pop_front();
      n_checks++;
      if (got_cnt_q.size() == 0) $display("FAIL bp_result: got none want (%0d,%0d)", e_c, e_s);
      else begin
        g_c = got_cnt_q.pop_front(); g_s = got_step_q.pop_front();
        if (g_c !== e_c || g_s !== e_s) $display("FAIL bp_result: got (%0d,%0d) want (%0d,%0d)", g_c, g_s, e_c, e_s);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_cnt_q.size() != 0 || done_seen != 1 || up_steps != 1)
      $display("FAIL bp_end: got extra=%0d done=%0d up=%0d want 0 1 1", got_cnt_q.size(), done_seen, up_steps);
    else n_pass++;
  endtask

  task automatic test_zero_steps(input logic [15:0] d, input int exp_c);
    gap_and_clear();
    result_ready = 1'b1;
    exp_cnt_q.push_back(exp_c); exp_step_q.push_back(0);
    do_start(8'd0, d, 3'd7, 1'b1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL zero_start_wins: got busy=%b want 1", busy);
    else n_pass++;
    observe(500);
    while (exp_cnt_q.size() > 0) begin
      e_c = exp_cnt_q.pop_front(); e_s = exp_step_q.pop_front();
      n_checks++;
      if (got_cnt_q.size() == 0) $display("FAIL zero_result: got none want (%0d,%0d)", e_c, e_s);
      else begin
        g_c = got_cnt_q.pop_front(); g_s = got_step_q.pop_front();
        if (g_c !== e_c || g_s !== e_s) $display("FAIL zero_result: got (%0d,%0d) want (%0d,%0d)", g_c, g_s, e_c, e_s);
        else n_pass++;
      end
    end
    n_checks++;
    if (up_steps + dn_steps != 0 || done_seen != 1 || got_cnt_q.size() != 0)
      $display("FAIL zero_end: got steps=%0d done=%0d extra=%0d want 0 1 0", up_steps + dn_steps, done_seen, got_cnt_q.size());
    else n_pass++;
  endtask

  task automatic test_saturation();
    gap_and_clear();
    result_ready = 1'b1;
    det_hold = 1'b1;
    exp_cnt_q.push_back(16'hFFFF); exp_step_q.push_back(0);
    do_start(8'd0, 16'hFFFF, 3'd0, 1'b0);
    observe(70000);
    det_hold = 1'b0;
    while (exp_cnt_q.size() > 0) begin
      e_c = exp_cnt_q.pop_front(); e_s = exp_step_q.pop_front();
      n_checks++;
      if (got_cnt_q.size() == 0) $display("FAIL sat_result: got none want (%0d,%0d)", e_c, e_s);
      else begin
        g_c = got_cnt_q.pop_front(); g_s = got_step_q.pop_front();
        if (g_c !== e_c || g_s !== e_s) $display("FAIL sat_result: got (%0d,%0d) want (%0d,%0d)", g_c, g_s, e_c, e_s);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    int n, wc;
    gap_and_clear();
    result_ready = 1'b1;
    pll_stuck = 1'b1;
    do_start(8'd1, 16'd2, 3'd1, 1'b0);
    n = 0;
    while (!phasestep && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (phasestep && n < 400) begin
      @(negedge clk);
      n++;
    end
    wc = 0;
    while (!error && wc < 400) begin
      wc++;
      @(negedge clk);
    end
    pll_stuck = 1'b0;
    n_checks++;
    if (wc != TIMEOUT) $display("FAIL timeout_cycles: got %0d want %0d", wc, TIMEOUT);
    else n_pass++;
    n_checks++;
    if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_end: got err=%b done=%b busy=%b want 1 1 0", error, done, busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    int n;
    gap_and_clear();
    result_ready = 1'b1;
    do_start(8'd2, 16'd10, 3'd3, 1'b0);
    n = 0;
    while (!phasestep && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!phasestep) $display("FAIL abort_reach_step: got phasestep=0 want 1 within 200 cycles");
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (phasestep !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || error !== 1'b0)
      $display("FAIL abort_end: got step=%b done=%b busy=%b valid=%b err=%b want 0 1 0 0 0",
               phasestep, done, busy, result_valid, error);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || phasestep !== 1'b0) $display("FAIL abort_after: got done=%b step=%b want 0 0", done, phasestep);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [32:0] outs;
    gap_and_clear();
    result_ready = 1'b1;
    do_start(8'd2, 16'd10, 3'd5, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (vetoLast !== 3'd5 || busy !== 1'b1) $display("FAIL rst_mid_busy: got veto=%0d busy=%b want 5 1", vetoLast, busy);
    else n_pass++;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    outs = {phasestep, phaseupdown, vetoLast, result_count, result_step,
            result_valid, busy, done, error};
    n_checks++;
    if (outs !== 33'd0) $display("FAIL rst_mid_outputs: got %h want 0", outs);
    else n_pass++;
    observe(60);
    n_checks++;
    if (done_seen != 0 || up_steps + dn_steps != 0 || step_run != 0)
      $display("FAIL rst_mid_quiet: got done=%0d steps=%0d run=%0d want 0 0 0", done_seen, up_steps + dn_steps, step_run);
    else n_pass++;
  endtask

`ifdef PHASE_SCAN_RETURN_EN
  task automatic test_return();
    gap_and_clear();
    result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_cnt_q.push_back(1);
      exp_step_q.push_back(i);
    end
    do_start(8'd3, 16'd2, 3'd0, 1'b0);
    observe(3000);
    while (exp_cnt_q.size() > 0) begin
      e_c = exp_cnt_q.pop_front(); e_s = exp_step_q.pop_front();
      n_checks++;
      if (got_cnt_q.size() == 0) $display("FAIL ret_result: got none want (%0d,%0d)", e_c, e_s);
      else begin
        g_c = got_cnt_q.pop_front(); g_s = got_step_q.pop_front();
        if (g_c !== e_c || g_s !== e_s) $display("FAIL ret_result: got (%0d,%0d) want (%0d,%0d)", g_c, g_s, e_c, e_s);
        else n_pass++;
      end
    end
    n_checks++;
    if (up_steps != 3 || dn_steps != 3 || order_bad != 0 || bad_width != 0 || done_seen != 1)
      $display("FAIL ret_steps: got up=%0d dn=%0d ord=%0d badw=%0d done=%0d want 3 3 0 0 1",
               up_steps, dn_steps, order_bad, bad_width, done_seen);
    else n_pass++;
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got simulation time limit want bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
    num_steps = 8'd0; dwell = 16'd0; veto_cfg = 3'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_steps(16'd3, 2);
    test_zero_steps(16'd0, 1);
    test_timeout();
    test_abort();
    test_reset_mid();
`ifdef PHASE_SCAN_RETURN_EN
    test_return();
`endif
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
